// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state and reset-cause encodings for the reset sequencer
package rst_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } seq_state_t;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;
  localparam logic [1:0] CAUSE_TMO  = 2'b11;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser, async active-low reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_rst_sequencer.sv
// rtl/clk_rst_sequencer.sv - PLL reset pulse, lock qualification and system reset release
module clk_rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RST_HOLD_CYCLES     = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int CNT_W               = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_rst_req,
  output logic       pll_areset,
  output logic       sys_rst_n,
  output logic [1:0] reset_cause,
  output logic [7:0] relock_count,
  output logic [2:0] seq_state
);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  seq_state_t       state;
  seq_state_t       next_state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cause_nxt;
  logic             relock_inc;

  logic locked_s;
  logic sw_s;
  logic locked_d;
  logic sw_d;
  logic sw_rise;

  sync_2ff u_sync_lock (.clk(clk), .rst_n(rst_n), .d(pll_locked), .q(locked_s));
  sync_2ff u_sync_sw   (.clk(clk), .rst_n(rst_n), .d(sw_rst_req), .q(sw_s));

  // RUN-state events are taken from one extra register stage so that lock loss
  // and a software edge arriving together are seen on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PLL_RST;
      cnt          <= '0;
      sys_rst_n    <= 1'b0;
      reset_cause  <= CAUSE_POR;
      relock_count <= 8'd0;
      locked_d     <= 1'b0;
      sw_d         <= 1'b0;
      sw_rise      <= 1'b0;
    end else begin
      state       <= next_state;
      sys_rst_n   <= (next_state == RUN);
      reset_cause <= cause_nxt;
      locked_d    <= locked_s;
      sw_d        <= sw_s;
      sw_rise     <= sw_s & ~sw_d;
      if (next_state != state) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      if (relock_inc && (relock_count != 8'hFF)) begin
        relock_count <= relock_count + 8'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    cause_nxt  = reset_cause;
    relock_inc = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == PLL_RST_LAST) next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          next_state = STABLE;
        end else if (cnt == TMO_LAST) begin
          next_state = PLL_RST;
          cause_nxt  = CAUSE_TMO;
        end
      end
      STABLE: begin
        if (!locked_s) next_state = WAIT_LOCK;
        else if (cnt == STABLE_LAST) next_state = HOLD;
      end
      HOLD: begin
        if (!locked_s) begin
          next_state = PLL_RST;
          cause_nxt  = CAUSE_LOCK;
        end else if (cnt == HOLD_LAST) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (!locked_d) begin
          next_state = PLL_RST;
          cause_nxt  = CAUSE_LOCK;
          relock_inc = 1'b1;
        end else if (sw_rise) begin
          next_state = HOLD;
          cause_nxt  = CAUSE_SW;
        end
      end
      default: next_state = PLL_RST;
    endcase
  end

  always_comb begin
    pll_areset = (state == PLL_RST);
    seq_state  = state;
  end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// tb/tb_clk_rst_sequencer.sv - directed/randomised self-checking bench for clk_rst_sequencer
module tb_clk_rst_sequencer;

  localparam int P_RST = 4;
  localparam int P_STB = 8;
  localparam int P_HLD = 4;
  localparam int P_TMO = 32;

  // Steps counted from the input change to the first observation of the effect.
  localparam int RISE_STEPS = 2 + P_STB + P_HLD + 1;
  localparam int LOSS_STEPS = 3 + 1;
  localparam int SW_STEPS   = 3 + 1;

  localparam int SEL_SYS = 0;
  localparam int SEL_ARE = 1;
  localparam int SEL_ST  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       pll_areset;
  logic       sys_rst_n;
  logic [1:0] reset_cause;
  logic [7:0] relock_count;
  logic [2:0] seq_state;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic [1:0] exp_cause = 2'b00;

  clk_rst_sequencer #(
    .PLL_RST_CYCLES     (P_RST),
    .LOCK_STABLE_CYCLES (P_STB),
    .RST_HOLD_CYCLES    (P_HLD),
    .LOCK_TIMEOUT_CYCLES(P_TMO),
    .CNT_W              (17)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .sw_rst_req  (sw_rst_req),
    .pll_areset  (pll_areset),
    .sys_rst_n   (sys_rst_n),
    .reset_cause (reset_cause),
    .relock_count(relock_count),
    .seq_state   (seq_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] probe(input int sel);
    case (sel)
      SEL_SYS: return {2'b00, sys_rst_n};
      SEL_ARE: return {2'b00, pll_areset};
      default: return seq_state;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic [2:0] val, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (probe(sel) !== val && n < 200);
  endtask

  task automatic relock_to_run(input string tag);
    int n;
    wait_for(SEL_ARE, 3'd0, n);
    check({tag, "_areset_len"}, n, P_RST);
    repeat ($urandom_range(0, 5)) step();
    pll_locked = 1'b1;
    wait_for(SEL_SYS, 3'd1, n);
    check({tag, "_rise"}, n, RISE_STEPS);
  endtask

  initial begin
    int n;
    int j;
    int hi_seen;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    sw_rst_req = 1'b0;
    repeat (3) step();
    check("rst_areset", pll_areset, 1);
    check("rst_sys", sys_rst_n, 0);
    check("rst_state", seq_state, 0);
    check("rst_cause", reset_cause, 0);
    check("rst_count", relock_count, 0);

    // Power-up with lock arriving 10 cycles after release.
    rst_n = 1'b1;
    wait_for(SEL_ARE, 3'd0, n);
    check("pu_areset_len", n, P_RST);
    repeat (10 - P_RST) step();
    pll_locked = 1'b1;
    wait_for(SEL_SYS, 3'd1, n);
    check("pu_rise", n, RISE_STEPS);
    check("pu_state", seq_state, 4);
    check("pu_cause", reset_cause, exp_cause);
    check("pu_count", relock_count, exp_count);

    // Lock glitch during STABLE.
    rst_n = 1'b0;
    pll_locked = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    wait_for(SEL_ARE, 3'd0, n);
    check("gl_areset_len", n, P_RST);
    pll_locked = 1'b1;
    repeat (3) step();
    check("gl_stable", seq_state, 2);
    j = $urandom_range(0, 4);
    repeat (j) step();
    pll_locked = 1'b0;
    repeat (3) step();
    check("gl_wait_lock", seq_state, 1);
    check("gl_sys_low", sys_rst_n, 0);
    pll_locked = 1'b1;
    wait_for(SEL_SYS, 3'd1, n);
    check("gl_rise", n, RISE_STEPS);
    check("gl_count", relock_count, exp_count);

    // Repeated lock loss in RUN; counter saturates.
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 3)) step();
      pll_locked = 1'b0;
      wait_for(SEL_SYS, 3'd0, n);
      exp_cause = 2'b01;
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      if (i < 3 || i > 296) begin
        check("ll_fall", n, LOSS_STEPS);
        check("ll_areset", pll_areset, 1);
      end
      check("ll_cause", reset_cause, exp_cause);
      check("ll_count", relock_count, exp_count);
      relock_to_run("ll");
    end
    check("ll_saturated", relock_count, 255);

    // One-cycle software request in RUN.
    step();
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    hi_seen = 0;
    n = 1;
    while (sys_rst_n !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    check("sw_fall", n, SW_STEPS);
    check("sw_state", seq_state, 3);
    check("sw_cause", reset_cause, 2'b10);
    n = 0;
    do begin
      hi_seen = hi_seen | int'(pll_areset);
      step();
      n++;
    end while (sys_rst_n !== 1'b1 && n < 50);
    check("sw_low_len", n, P_HLD);
    check("sw_no_areset", hi_seen, 0);
    check("sw_count", relock_count, exp_count);

    // Software level held high triggers only once.
    sw_rst_req = 1'b1;
    wait_for(SEL_SYS, 3'd0, n);
    check("swh_fall", n, SW_STEPS);
    wait_for(SEL_SYS, 3'd1, n);
    check("swh_low_len", n, P_HLD);
    n = 0;
    repeat (20) begin
      step();
      if (sys_rst_n !== 1'b1) n++;
    end
    check("swh_no_retrigger", n, 0);
    sw_rst_req = 1'b0;
    repeat (4) step();

    // Lock loss and software request sampled on the same edge.
    pll_locked = 1'b0;
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    n = 1;
    while (sys_rst_n !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    check("sim_fall", n, LOSS_STEPS);
    check("sim_areset", pll_areset, 1);
    check("sim_cause", reset_cause, 2'b01);
    check("sim_count", relock_count, 255);
    relock_to_run("sim");

    // rst_n asserted while in HOLD.
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    wait_for(SEL_ST, 3'd3, n);
    check("hr_hold", n, SW_STEPS - 1);
    check("hr_cause_pre", reset_cause, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("hr_state", seq_state, 0);
    check("hr_areset", pll_areset, 1);
    check("hr_sys", sys_rst_n, 0);
    check("hr_cause", reset_cause, 0);
    check("hr_count", relock_count, 0);

    // Lock never arrives: periodic re-pulse with timeout cause.
    pll_locked = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    wait_for(SEL_ARE, 3'd0, n);
    check("to_areset_first", n, P_RST);
    check("to_cause_first", reset_cause, 0);
    for (int i = 0; i < 3; i++) begin
      wait_for(SEL_ARE, 3'd1, n);
      check("to_wait_len", n, P_TMO);
      check("to_cause", reset_cause, 2'b11);
      check("to_sys", sys_rst_n, 0);
      wait_for(SEL_ARE, 3'd0, n);
      check("to_areset_len", n, P_RST);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
